turn_input_cond: RTL and testbench

Input conditioner that sits directly upstream of the turn-signal FSM. Takes raw, asynchronous left/right lever switches, synchronizes and debounces each one, and drives the clean `left` / `right` levels into the FSM. Also generates a free-running one-cycle `tick` enable so the FSM and lamp logic can advance at a human-visible rate from the fast system clock.

---
 rtl/turn_input_cond.sv | 92 +++++++++
 tb/tb_turn_input_cond.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/turn_input_cond.sv
// Lever-switch conditioner: per-channel 2-flop sync + debounce, plus a free-running tick divider.
// Optional TURN_COND_ALIGN_EN: register left/right so they only change on tick edges.
module turn_input_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    output logic left,
    output logic right,
    output logic tick
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TCNT_MAX = TW'(TICK_DIV - 1);

    logic [1:0] raw;
    logic [1:0] deb;

    assign raw = {right_raw, left_raw};

    // Channel 0 = left, channel 1 = right; the two never interact.
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic          s1;
        logic          s2;
        logic          deb_q;
        logic [CW-1:0] cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                deb_q <= 1'b0;
                cnt   <= '0;
            end else begin
                s1 <= raw[ch];
                s2 <= s1;
                if (s2 == deb_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    deb_q <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign deb[ch] = deb_q;
    end

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (tcnt == TCNT_MAX) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign tick = (tcnt == TCNT_MAX);

`ifdef TURN_COND_ALIGN_EN
    logic left_q;
    logic right_q;

    // Sample the debounced levels only on tick so the FSM sees one coherent step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else if (tick) begin
            left_q  <= deb[0];
            right_q <= deb[1];
        end
    end

    assign left  = left_q;
    assign right = right_q;
`else
    assign left  = deb[0];
    assign right = deb[1];
`endif

endmodule

// File: tb/tb_turn_input_cond.sv
// Directed bench for turn_input_cond: expected left/right change events are queued by the
// drivers and popped by a monitor whenever the outputs change; tick is checked every cycle.
module tb_turn_input_cond;

    localparam int DEB  = 4;
    localparam int TDIV = 8;
    localparam int LAT  = DEB + 2;  // raw driven just after edge N -> deb changes on edge N+LAT
    localparam int W    = 18;       // {cycle[15:0], left, right}

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic left_raw = 1'b0;
    logic right_raw = 1'b0;
    logic left;
    logic right;
    logic tick;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int rel = 0;
    logic [1:0] prev_lr = 2'b00;
    logic [W-1:0] exp_q[$];

    turn_input_cond #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .left_raw  (left_raw),
        .right_raw (right_raw),
        .left      (left),
        .right     (right),
        .tick      (tick)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, got, want, cyc);
    endtask

    // Edge on which the visible outputs follow a deb change made on edge d.
    function automatic int out_edge(input int d);
`ifdef TURN_COND_ALIGN_EN
        return d + (TDIV - ((d - rel) % TDIV));
`else
        return d;
`endif
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic l, input logic r);
        exp_q.push_back({at[15:0], l, r});
    endtask

    // Drive both levers just after an edge and queue the resulting output event.
    task automatic drive(input logic l, input logic r);
        left_raw  = l;
        right_raw = r;
        push(out_edge(cyc + LAT), l, r);
    endtask

    task automatic do_reset_release();
        reset = 1'b0;
        rel   = cyc;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic exp_tick;
        exp_tick = !reset && (cyc > rel) && (((cyc - rel) % TDIV) == TDIV - 1);
        check("tick", int'(tick), int'(exp_tick));
        if ({left, right} != prev_lr) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL lr_unexpected got lr=%b%b at cyc %0d want no change", left, right, cyc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (e == {cyc[15:0], left, right}) passed++;
                else $display("FAIL lr_event got cyc=%0d lr=%b%b want cyc=%0d lr=%b%b",
                              cyc, left, right, e[W-1:2], e[1], e[0]);
            end
            prev_lr = {left, right};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        #1;
        check("reset_left", int'(left), 0);
        check("reset_right", int'(right), 0);
        check("reset_tick", int'(tick), 0);
        wait_cycles(3);
        do_reset_release();

        // Free run: tick pattern checked by the monitor.
        wait_cycles(40);

        // Clean left press, then release.
        drive(1'b1, 1'b0);
        wait_cycles(10);
        drive(1'b0, 1'b0);
        wait_cycles(12);

        // Bounce on right: 3 high, 1 low, 3 high, 4 low -> rejected.
        right_raw = 1'b1; wait_cycles(3);
        right_raw = 1'b0; wait_cycles(1);
        right_raw = 1'b1; wait_cycles(3);
        right_raw = 1'b0; wait_cycles(4);
        drive(1'b0, 1'b1);
        wait_cycles(10);
        drive(1'b0, 1'b0);
        wait_cycles(12);

        // Hazard: both levers at once pass straight through together.
        drive(1'b1, 1'b1);
        wait_cycles(10);
        drive(1'b0, 1'b0);
        wait_cycles(12);

        // Asynchronous reset with left held and debounced high.
        drive(1'b1, 1'b0);
        wait_cycles(12);
        check("pre_reset_left", int'(left), 1);
        push(cyc, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("async_left", int'(left), 0);
        check("async_right", int'(right), 0);
        check("async_tick", int'(tick), 0);
        wait_cycles(3);
        do_reset_release();
        push(out_edge(cyc + LAT), 1'b1, 1'b0);
        wait_cycles(12);
        drive(1'b0, 1'b0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            wait_cycles(1);
            guard++;
        end
        wait_cycles(4);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
